// File: rtl/ppu_ctrl_timing.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_ctrl_timing
//  Purpose  : PPU register file and beam timing. Implements the CPU-visible
//             registers ($0-$7): PPUCTRL, PPUMASK, PPUSTATUS, OAMADDR/OAMDATA,
//             PPUSCROLL, PPUADDR, PPUDATA. Also provides the dot/scanline beam
//             counter, the vblank flag and the NMI output.
//  Ports    : clk, reset_n          - clock, async active-low reset
//             ppu_ce                - advance the beam one dot
//             cpu_addr/data_in/wren/rden, cpu_data_out - CPU register port
//             nmi_n                 - active-low NMI (vblank & ctrl[7])
//             oam_*                 - OAM address / write port / read data
//             ppu_*                 - PPU bus (address = v, read/write pulses)
//             ctrl, mask, scroll_x, scroll_y - register contents
//             dot, scanline         - beam position
//             busy                  - PPUDATA access sequence in progress
//  Revision : 1.0  initial release
// ============================================================================
module ppu_ctrl_timing #(
   parameter int DOTS_PER_LINE   = 341,
   parameter int LINES_PER_FRAME = 262,
   parameter int VBLANK_LINE     = 241,
   parameter int PRERENDER_LINE  = 261,
   parameter int ADDR_W          = 14
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ppu_ce,
   input  logic [2:0]        cpu_addr,
   input  logic [7:0]        cpu_data_in,
   input  logic              cpu_wren,
   input  logic              cpu_rden,
   output logic [7:0]        cpu_data_out,
   output logic              nmi_n,
   input  logic [7:0]        oam_rdata,
   output logic [7:0]        oam_addr,
   output logic [7:0]        oam_wdata,
   output logic              oam_we,
   input  logic [7:0]        ppu_data_in,
   output logic [7:0]        ppu_data_out,
   output logic [ADDR_W-1:0] ppu_addr,
   output logic              ppu_write,
   output logic              ppu_read,
   output logic [7:0]        ctrl,
   output logic [7:0]        mask,
   output logic [7:0]        scroll_x,
   output logic [7:0]        scroll_y,
   output logic [8:0]        dot,
   output logic [8:0]        scanline,
   output logic              busy
);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_WR         = 2'd1;
   localparam logic [1:0] S_RD_ISSUE   = 2'd2;
   localparam logic [1:0] S_RD_CAPTURE = 2'd3;

   logic [1:0]        r_state;
   logic [8:0]        r_dot;
   logic [8:0]        r_scanline;
   logic              r_vblank;
   logic              r_supp;
   logic [7:0]        r_ctrl;
   logic [7:0]        r_mask;
   logic [7:0]        r_scroll_x;
   logic [7:0]        r_scroll_y;
   logic [7:0]        r_oam_addr;
   logic [7:0]        r_oam_wdata;
   logic              r_oam_we;
   logic              r_w;
   logic [5:0]        r_t;
   logic [ADDR_W-1:0] r_v;
   logic [7:0]        r_buffer;
   logic [7:0]        r_ppu_wdata;
   logic [7:0]        r_last_write;
   logic [7:0]        r_cpu_data_out;

   logic              w_wr;
   logic              w_rd;
   logic              w_busy;
   logic              w_rd_ok;
   logic              w_rd_status;
   logic              w_at_vbl;
   logic              w_at_pre;
   logic              w_dot_last;
   logic              w_line_last;
   logic [ADDR_W-1:0] w_inc;

   // A simultaneous write wins; the read is simply ignored.
   assign w_wr        = cpu_wren;
   assign w_rd        = cpu_rden & ~cpu_wren;
   assign w_busy      = (r_state != S_IDLE);
   // A $7 read while a PPUDATA sequence is running is dropped entirely.
   assign w_rd_ok     = w_rd & ~((cpu_addr == 3'd7) & w_busy);
   assign w_rd_status = w_rd & (cpu_addr == 3'd2);
   // Flag events are decoded from the current beam position at the ppu_ce edge.
   assign w_at_vbl    = (r_scanline == 9'(VBLANK_LINE))    && (r_dot == 9'd1);
   assign w_at_pre    = (r_scanline == 9'(PRERENDER_LINE)) && (r_dot == 9'd1);
   assign w_dot_last  = (r_dot == 9'(DOTS_PER_LINE - 1));
   assign w_line_last = (r_scanline == 9'(LINES_PER_FRAME - 1));
   assign w_inc       = r_ctrl[2] ? ADDR_W'(32) : ADDR_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_dot          <= '0;
         r_scanline     <= '0;
         r_vblank       <= 1'b0;
         r_supp         <= 1'b0;
         r_ctrl         <= '0;
         r_mask         <= '0;
         r_scroll_x     <= '0;
         r_scroll_y     <= '0;
         r_oam_addr     <= '0;
         r_oam_wdata    <= '0;
         r_oam_we       <= 1'b0;
         r_w            <= 1'b0;
         r_t            <= '0;
         r_v            <= '0;
         r_buffer       <= '0;
         r_ppu_wdata    <= '0;
         r_last_write   <= '0;
         r_cpu_data_out <= '0;
      end else begin
         // Beam counter
         if (ppu_ce) begin
            if (w_dot_last) begin
               r_dot      <= '0;
               r_scanline <= w_line_last ? 9'd0 : r_scanline + 9'd1;
            end else begin
               r_dot <= r_dot + 9'd1;
            end
         end

         // Vblank flag. A status read landing on the set point kills the set
         // for the whole frame; r_supp remembers that until pre-render.
         if (w_rd_status) begin
            r_vblank <= 1'b0;
         end else if (ppu_ce && w_at_vbl && !r_supp) begin
            r_vblank <= 1'b1;
         end else if (ppu_ce && w_at_pre) begin
            r_vblank <= 1'b0;
         end

         if (w_rd_status && w_at_vbl) begin
            r_supp <= 1'b1;
         end else if (ppu_ce && w_at_pre) begin
            r_supp <= 1'b0;
         end

         // OAM write pulse; the address advances once the pulse has been seen.
         r_oam_we <= w_wr && (cpu_addr == 3'd4);
         if (w_wr && (cpu_addr == 3'd4)) begin
            r_oam_wdata <= cpu_data_in;
         end
         if (w_wr && (cpu_addr == 3'd3)) begin
            r_oam_addr <= cpu_data_in;
         end else if (r_oam_we) begin
            r_oam_addr <= r_oam_addr + 8'd1;
         end

         // PPUDATA sequencer. v advances after the bus pulse so the pulse
         // cycle presents the pre-increment address.
         case (r_state)
            S_IDLE: begin
               if (w_wr && (cpu_addr == 3'd7)) begin
                  r_state <= S_WR;
               end else if (w_rd && (cpu_addr == 3'd7)) begin
                  r_state <= S_RD_ISSUE;
               end
            end
            S_WR: begin
               r_v     <= r_v + w_inc;
               r_state <= S_IDLE;
            end
            S_RD_ISSUE: begin
               r_v     <= r_v + w_inc;
               r_state <= S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
               r_buffer <= ppu_data_in;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         // CPU register writes (placed after the sequencer so a $6 load of v
         // takes precedence over a concurrent increment).
         if (w_wr) begin
            r_last_write <= cpu_data_in;
            case (cpu_addr)
               3'd0: r_ctrl <= cpu_data_in;
               3'd1: r_mask <= cpu_data_in;
               3'd5: begin
                  if (!r_w) r_scroll_x <= cpu_data_in;
                  else      r_scroll_y <= cpu_data_in;
                  r_w <= ~r_w;
               end
               3'd6: begin
                  if (!r_w) r_t <= cpu_data_in[5:0];
                  else      r_v <= ADDR_W'({r_t, cpu_data_in});
                  r_w <= ~r_w;
               end
               3'd7: begin
                  if (!w_busy) r_ppu_wdata <= cpu_data_in;
               end
               default: ;
            endcase
         end else if (w_rd_status) begin
            r_w <= 1'b0;
         end

         // CPU read data, held until the next accepted read
         if (w_rd_ok) begin
            case (cpu_addr)
               3'd2:    r_cpu_data_out <= {r_vblank, 2'b00, r_last_write[4:0]};
               3'd4:    r_cpu_data_out <= oam_rdata;
               3'd7:    r_cpu_data_out <= r_buffer;
               default: r_cpu_data_out <= r_last_write;
            endcase
         end
      end
   end

   assign cpu_data_out = r_cpu_data_out;
   assign nmi_n        = ~(r_vblank & r_ctrl[7]);
   assign oam_addr     = r_oam_addr;
   assign oam_wdata    = r_oam_wdata;
   assign oam_we       = r_oam_we;
   assign ppu_data_out = r_ppu_wdata;
   assign ppu_addr     = r_v;
   assign ppu_write    = (r_state == S_WR);
   assign ppu_read     = (r_state == S_RD_ISSUE);
   assign ctrl         = r_ctrl;
   assign mask         = r_mask;
   assign scroll_x     = r_scroll_x;
   assign scroll_y     = r_scroll_y;
   assign dot          = r_dot;
   assign scanline     = r_scanline;
   assign busy         = w_busy;

endmodule
`default_nettype wire
